program_memory_arbiter: RTL
===========================

// Module: program_memory_arbiter
// PURPOSE
//  Shares the single asynchronous-read port of the program ROM between the instruction-fetch requester (F)
//  and a data/debug read requester (D, e.g. loads from the text segment, test loader readback).
//  Converts byte addresses to word indices, registers the ROM word, and returns it through a
//  per-requester valid/ready response channel. Sits between the PC/fetch logic and ProgramMemory-style ROM.
// PARAMETERS
//  MEMORY_DEPTH   32  number of ROM words; word index >= MEMORY_DEPTH is out of range
//  DATA_WIDTH     32  address and data width
//  ROM_AW         5   width of rom_addr (must satisfy 2**ROM_AW >= MEMORY_DEPTH)
//  STARVE_LIMIT   4   consecutive lost arbitrations after which D wins (fixed-priority mode only), >=1
// PORTS
//  clk        in   1           rising-edge clock
//  reset      in   1           synchronous, active-high reset
//  f_req      in   1           fetch request; f_addr must be stable while f_req=1 and f_gnt=0
//  f_addr     in   DATA_WIDTH  fetch byte address
//  f_gnt      out  1           combinational: F request accepted this cycle
//  f_rvalid   out  1           F response valid (registered)
//  f_rdata    out  DATA_WIDTH  F response word
//  f_rerr     out  1           F response error (misaligned or out of range)
//  f_rready   in   1           F consumes response when f_rvalid & f_rready
//  d_req/d_addr/d_gnt/d_rvalid/d_rdata/d_rerr/d_rready   same as F, for the D requester
//  rom_addr   out  ROM_AW      word index to ROM (combinational from granted requester's address)
//  rom_data   in   DATA_WIDTH  ROM word, combinational from rom_addr
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE, all rvalid/rerr=0, rdata=0, starve_cnt=0, rr_last=D; rom_addr=0 when idle.
//  - States: IDLE (no outstanding response), RESP_F, RESP_D (one response held for the owner).
//  - Accept allowed when state=IDLE, or in RESP_x in the same cycle the held response is consumed
//    (rvalid & rready) -> back-to-back throughput of 1 word/cycle. Never more than one response outstanding.
//  - Grant: only one of f_gnt/d_gnt high per cycle; gnt implies req. Only one requester -> it wins.
//  - Both requesting (fixed priority): F wins; starve_cnt++ each cycle D requests, is eligible and loses;
//    when starve_cnt == STARVE_LIMIT, D wins next eligible cycle. starve_cnt clears on D grant or d_req=0.
//  - Latency: grant in cycle N -> rom_addr = addr[ROM_AW+1:2] in cycle N; rdata/rvalid registered at edge
//    ending N, visible in N+1. Response held stable (rdata, rerr, rvalid) until consumed.
//  - Errors: addr[1:0]!=0 -> rerr=1, rdata = word at addr>>2 (truncated index). addr>>2 >= MEMORY_DEPTH
//    -> rerr=1, rdata=0 (ROM data ignored). Otherwise rerr=0.
//  - Requester may drop req before grant with no effect; no abort once granted.
//  - Reset mid-operation: held response discarded, rvalid=0 next cycle, no further ROM access.
//  - rready while rvalid=0 is ignored; rvalid of the non-owner is always 0.
// CONFIGURATION
//  PM_ARB_ROUND_ROBIN_EN defined: when both request, grant goes to the requester not granted last (rr_last,
//    updated on every grant; reset value D so F wins the first tie); STARVE_LIMIT and starve_cnt unused.
//  Not defined: fixed priority F > D with the STARVE_LIMIT anti-starvation rule above.
// TESTING
//  1 reset=1 two cycles while f_req=1 -> f_gnt=0, f_rvalid=0, f_rdata=0; release -> f_gnt=1 next cycle.
//  2 ROM word i = 32'hA000_0000+i; f_req held, f_addr=0,4,8 each cycle, f_rready=1 -> f_rvalid=1 three
//    consecutive cycles, rdata A0000000/A0000001/A0000002, 1-cycle latency, rerr=0.
//  3 f_req & d_req continuously, rready=1, fixed priority, STARVE_LIMIT=4 -> pattern F,F,F,F,D repeating;
//    with PM_ARB_ROUND_ROBIN_EN -> F,D,F,D alternating.
//  4 d_addr=32'h0000_0006 -> d_rerr=1, d_rdata=A0000001; d_addr=32'h80 (index 32) -> d_rerr=1, d_rdata=0.
//  5 F response with f_rready=0 for 3 cycles while d_req=1 -> f_rdata/f_rvalid stable, d_gnt=0;
//    cycle f_rready=1 -> d_gnt=1 same cycle, d_rvalid next cycle.
//  6 reset asserted while f_rvalid=1 held -> f_rvalid=0 next cycle, no grant during reset.

Source files
------------

// File: rtl/program_memory_arbiter.sv
// program_memory_arbiter: shares one async-read program ROM port between fetch (F) and data/debug (D) requesters.
//   Ports: clk, reset (sync, active-high); per requester x in {f,d}: x_req/x_addr in, x_gnt out (combinational),
//   x_rvalid/x_rdata/x_rerr out (registered), x_rready in; rom_addr out (word index), rom_data in.
//   Config: define PM_ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed F>D with starvation limit.
module program_memory_arbiter #(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int ROM_AW       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  f_req,
  input  logic [DATA_WIDTH-1:0] f_addr,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  output logic [DATA_WIDTH-1:0] f_rdata,
  output logic                  f_rerr,
  input  logic                  f_rready,
  input  logic                  d_req,
  input  logic [DATA_WIDTH-1:0] d_addr,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_rerr,
  input  logic                  d_rready,
  output logic [ROM_AW-1:0]     rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data
);
  typedef enum logic [1:0] {IDLE, RESP_F, RESP_D} state_t;
  state_t state_q, state_d;
  logic accept, pick_d, oor, err;
  logic [DATA_WIDTH-1:0] sel_addr, word;
  logic [DATA_WIDTH-1:0] f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;
  logic f_rerr_q, f_rerr_d, d_rerr_q, d_rerr_d;
`ifdef PM_ARB_ROUND_ROBIN_EN
  logic rr_last_q, rr_last_d;
`else
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q, starve_d;
`endif
  always_comb begin
    // a new request is taken only when no response is held, or the held one leaves this cycle
    accept = !reset && (state_q == IDLE || (state_q == RESP_F && f_rready) || (state_q == RESP_D && d_rready));
`ifdef PM_ARB_ROUND_ROBIN_EN
    pick_d = d_req && (!f_req || !rr_last_q);
    rr_last_d = d_gnt ? 1'b1 : f_gnt ? 1'b0 : rr_last_q;
`else
    pick_d = d_req && (!f_req || starve_q == SW'(STARVE_LIMIT));
`endif
    d_gnt = accept && pick_d;
    f_gnt = accept && f_req && !pick_d;
`ifndef PM_ARB_ROUND_ROBIN_EN
    // D lost only if it was eligible, which means F took the slot
    starve_d = (!d_req || d_gnt) ? '0 : (f_gnt && starve_q != SW'(STARVE_LIMIT)) ? starve_q + SW'(1) : starve_q;
`endif
    sel_addr = d_gnt ? d_addr : f_gnt ? f_addr : '0;
    rom_addr = sel_addr[ROM_AW+1:2];
    oor = sel_addr[DATA_WIDTH-1:2] >= (DATA_WIDTH-2)'(MEMORY_DEPTH);
    err = oor || (sel_addr[1:0] != 2'b00);
    word = oor ? '0 : rom_data;
    state_d = f_gnt ? RESP_F : d_gnt ? RESP_D : accept ? IDLE : state_q;
    f_rdata_d = f_gnt ? word : f_rdata_q;
    f_rerr_d = f_gnt ? err : f_rerr_q;
    d_rdata_d = d_gnt ? word : d_rdata_q;
    d_rerr_d = d_gnt ? err : d_rerr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      f_rdata_q <= '0;
      f_rerr_q <= 1'b0;
      d_rdata_q <= '0;
      d_rerr_q <= 1'b0;
`ifdef PM_ARB_ROUND_ROBIN_EN
      rr_last_q <= 1'b1;
`else
      starve_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      f_rdata_q <= f_rdata_d;
      f_rerr_q <= f_rerr_d;
      d_rdata_q <= d_rdata_d;
      d_rerr_q <= d_rerr_d;
`ifdef PM_ARB_ROUND_ROBIN_EN
      rr_last_q <= rr_last_d;
`else
      starve_q <= starve_d;
`endif
    end
  end
  assign f_rvalid = state_q == RESP_F;
  assign d_rvalid = state_q == RESP_D;
  assign f_rdata = f_rdata_q;
  assign f_rerr = f_rerr_q;
  assign d_rdata = d_rdata_q;
  assign d_rerr = d_rerr_q;
endmodule
